// File: rtl/seg_mux_ctrl_if.sv
// Upstream value bus and downstream decoder/anode signals of the seven-segment mux controller.
// The master side is the value source; the slave side is seg_mux_ctrl.
interface seg_mux_ctrl_if;
  logic       load;
  logic [3:0] hex_a;
  logic [3:0] hex_b;
  logic [3:0] hex_sel;
  logic [1:0] an_en;
  logic       pending;
  logic       frame_tick;

  modport master (
    output load, hex_a, hex_b,
    input  hex_sel, an_en, pending, frame_tick
  );

  modport slave (
    input  load, hex_a, hex_b,
    output hex_sel, an_en, pending, frame_tick
  );
endinterface

// File: rtl/seg_mux_ctrl.sv
// Two-digit seven-segment time-multiplexer: BLANK_A/SHOW_A/BLANK_B/SHOW_B with frame-boundary commit.
// Optional SEG_MUX_LEADING_ZERO_BLANK_EN keeps digit A dark while its committed value is zero.
module seg_mux_ctrl #(
  parameter int unsigned DWELL_CYCLES = 24000,
  parameter int unsigned BLANK_CYCLES = 240
) (
  input  logic          clk,
  input  logic          reset,
  seg_mux_ctrl_if.slave bus
);

  localparam int unsigned MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    BLANK_A,
    SHOW_A,
    BLANK_B,
    SHOW_B
  } state_e;

  state_e           state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [3:0]       stage_a_q,    stage_a_d;
  logic [3:0]       stage_b_q,    stage_b_d;
  logic [3:0]       disp_a_q,     disp_a_d;
  logic [3:0]       disp_b_q,     disp_b_d;
  logic             pending_q,    pending_d;
  logic [3:0]       hex_sel_q,    hex_sel_d;
  logic [1:0]       an_en_q,      an_en_d;
  logic             frame_tick_q, frame_tick_d;
  logic             phase_done;
  logic             commit;

  // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    phase_done = (state_q == BLANK_A || state_q == BLANK_B) ? (cnt_q == BLANK_LAST)
                                                            : (cnt_q == DWELL_LAST);
    commit     = phase_done && (state_q == SHOW_B);
    cnt_d      = phase_done ? '0 : cnt_q + 1'b1;

    state_d = state_q;
    if (phase_done) begin
      unique case (state_q)
        BLANK_A: state_d = SHOW_A;
        SHOW_A:  state_d = BLANK_B;
        BLANK_B: state_d = SHOW_B;
        SHOW_B:  state_d = BLANK_A;
      endcase
    end

    stage_a_d = bus.load ? bus.hex_a : stage_a_q;
    stage_b_d = bus.load ? bus.hex_b : stage_b_q;
    disp_a_d  = disp_a_q;
    disp_b_d  = disp_b_q;
    pending_d = pending_q;

    // A load landing on the commit edge bypasses staging so the new frame already shows it.
    if (commit) begin
      pending_d = 1'b0;
      if (bus.load) begin
        disp_a_d = bus.hex_a;
        disp_b_d = bus.hex_b;
      end else if (pending_q) begin
        disp_a_d = stage_a_q;
        disp_b_d = stage_b_q;
      end
    end else if (bus.load) begin
      pending_d = 1'b1;
    end

    // Outputs are decoded from the state being entered, so hex_sel changes at blank entry.
    an_en_d   = 2'b11;
    hex_sel_d = disp_a_d;
    unique case (state_d)
      BLANK_A: begin
        an_en_d   = 2'b11;
        hex_sel_d = disp_a_d;
      end
      SHOW_A: begin
`ifdef SEG_MUX_LEADING_ZERO_BLANK_EN
        an_en_d   = (disp_a_d == 4'h0) ? 2'b11 : 2'b10;
`else
        an_en_d   = 2'b10;
`endif
        hex_sel_d = disp_a_d;
      end
      BLANK_B: begin
        an_en_d   = 2'b11;
        hex_sel_d = disp_b_d;
      end
      SHOW_B: begin
        an_en_d   = 2'b01;
        hex_sel_d = disp_b_d;
      end
    endcase

    frame_tick_d = commit;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= BLANK_A;
      cnt_q        <= '0;
      // NOTE: staging and display registers are reset too; a reset must discard any staged value.
      stage_a_q    <= 4'h0;
      stage_b_q    <= 4'h0;
      disp_a_q     <= 4'h0;
      disp_b_q     <= 4'h0;
      pending_q    <= 1'b0;
      hex_sel_q    <= 4'h0;
      an_en_q      <= 2'b11;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stage_a_q    <= stage_a_d;
      stage_b_q    <= stage_b_d;
      disp_a_q     <= disp_a_d;
      disp_b_q     <= disp_b_d;
      pending_q    <= pending_d;
      hex_sel_q    <= hex_sel_d;
      an_en_q      <= an_en_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.hex_sel    = hex_sel_q;
  assign bus.an_en      = an_en_q;
  assign bus.pending    = pending_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_mux_ctrl.sv
// Bench for seg_mux_ctrl with DWELL=4, BLANK=2 (12-cycle frames): vector table, reset and
// leading-zero sequences, then random loads against a frame-position reference model.
module tb_seg_mux_ctrl;

  localparam int DWELL = 4;
  localparam int BLANK = 2;
  localparam int FRAME = 2 * (DWELL + BLANK);
  localparam int NVEC  = 39;

  logic clk;
  logic reset;

  seg_mux_ctrl_if bus ();

  seg_mux_ctrl #(
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] an;
    logic [3:0] hs;
    logic       pend;
    logic       tick;
  } vec_t;

  vec_t tbl [NVEC];

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: time since reset release plus committed/staged pairs.
  int         m_t;
  logic [3:0] m_disp_a, m_disp_b, m_stage_a, m_stage_b;
  logic       m_pend;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [1:0] lz_adj(input logic [1:0] an, input logic [3:0] hs);
`ifdef SEG_MUX_LEADING_ZERO_BLANK_EN
    if (an == 2'b10 && hs == 4'h0) return 2'b11;
`endif
    return an;
  endfunction

  task automatic model_reset();
    m_t = 0;
    m_disp_a = 4'h0; m_disp_b = 4'h0;
    m_stage_a = 4'h0; m_stage_b = 4'h0;
    m_pend = 1'b0;
  endtask

  task automatic model_edge(input logic ld, input logic [3:0] a, input logic [3:0] b);
    m_t++;
    if (m_t % FRAME == 0) begin
      if (ld) begin
        m_disp_a = a; m_disp_b = b;
      end else if (m_pend) begin
        m_disp_a = m_stage_a; m_disp_b = m_stage_b;
      end
      m_pend = 1'b0;
    end else if (ld) begin
      m_stage_a = a; m_stage_b = b;
      m_pend = 1'b1;
    end
  endtask

  task automatic check_model(input string tag);
    int p;
    logic [1:0] an;
    logic [3:0] hs;
    p = m_t % FRAME;
    if (p < BLANK) begin
      an = 2'b11; hs = m_disp_a;
    end else if (p < BLANK + DWELL) begin
      an = lz_adj(2'b10, m_disp_a); hs = m_disp_a;
    end else if (p < 2 * BLANK + DWELL) begin
      an = 2'b11; hs = m_disp_b;
    end else begin
      an = 2'b01; hs = m_disp_b;
    end
    check({tag, ".an_en"},      {6'd0, bus.an_en},      {6'd0, an});
    check({tag, ".hex_sel"},    {4'd0, bus.hex_sel},    {4'd0, hs});
    check({tag, ".pending"},    {7'd0, bus.pending},    {7'd0, m_pend});
    check({tag, ".frame_tick"}, {7'd0, bus.frame_tick}, {7'd0, logic'(m_t > 0 && p == 0)});
  endtask

  // Drive inputs, let one edge pass, advance the model, return at the following negedge.
  task automatic step(input logic ld, input logic [3:0] a, input logic [3:0] b);
    bus.load = ld; bus.hex_a = a; bus.hex_b = b;
    @(posedge clk);
    model_edge(ld, a, b);
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic fill(input int lo, input int hi, input logic [1:0] an, input logic [3:0] hs,
                      input logic pend, input logic tick);
    for (int k = lo; k <= hi; k++)
      tbl[k] = '{ld: 1'b0, a: 4'h0, b: 4'h0, an: an, hs: hs, pend: pend, tick: tick};
  endtask

  task automatic set_load(input int k, input logic [3:0] a, input logic [3:0] b);
    tbl[k].ld = 1'b1; tbl[k].a = a; tbl[k].b = b;
  endtask

  initial begin
    // Entry k = outputs after the k-th edge since reset release (entry 0 = reset state).
    fill( 0,  1, 2'b11, 4'h0, 1'b0, 1'b0);
    fill( 2,  2, 2'b10, 4'h0, 1'b0, 1'b0);
    fill( 3,  5, 2'b10, 4'h0, 1'b1, 1'b0);
    fill( 6,  7, 2'b11, 4'h0, 1'b1, 1'b0);
    fill( 8, 11, 2'b01, 4'h0, 1'b1, 1'b0);
    fill(12, 12, 2'b11, 4'h3, 1'b0, 1'b1);
    fill(13, 13, 2'b11, 4'h3, 1'b0, 1'b0);
    fill(14, 17, 2'b10, 4'h3, 1'b1, 1'b0);
    fill(18, 19, 2'b11, 4'h7, 1'b1, 1'b0);
    fill(20, 23, 2'b01, 4'h7, 1'b1, 1'b0);
    fill(24, 24, 2'b11, 4'h4, 1'b0, 1'b1);
    fill(25, 25, 2'b11, 4'h4, 1'b0, 1'b0);
    fill(26, 29, 2'b10, 4'h4, 1'b0, 1'b0);
    fill(30, 31, 2'b11, 4'h5, 1'b0, 1'b0);
    fill(32, 35, 2'b01, 4'h5, 1'b0, 1'b0);
    fill(36, 36, 2'b11, 4'h9, 1'b0, 1'b1);
    fill(37, 37, 2'b11, 4'h9, 1'b0, 1'b0);
    fill(38, 38, 2'b10, 4'h9, 1'b0, 1'b0);
    set_load( 3, 4'h3, 4'h7);
    set_load(14, 4'h1, 4'h2);
    set_load(20, 4'h4, 4'h5);
    set_load(36, 4'h9, 4'hA);

    reset = 1'b0;
    bus.load = 1'b0; bus.hex_a = 4'h0; bus.hex_b = 4'h0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;

    for (int k = 0; k < NVEC; k++) begin
      if (k > 0) step(tbl[k].ld, tbl[k].a, tbl[k].b);
      check($sformatf("vec%0d.an_en", k),      {6'd0, bus.an_en},      {6'd0, lz_adj(tbl[k].an, tbl[k].hs)});
      check($sformatf("vec%0d.hex_sel", k),    {4'd0, bus.hex_sel},    {4'd0, tbl[k].hs});
      check($sformatf("vec%0d.pending", k),    {7'd0, bus.pending},    {7'd0, tbl[k].pend});
      check($sformatf("vec%0d.frame_tick", k), {7'd0, bus.frame_tick}, {7'd0, tbl[k].tick});
    end

    // Load 6,6 in SHOW_A, then assert reset asynchronously in the middle of SHOW_B.
    step(1'b1, 4'h6, 4'h6);
    check_model("load66");
    while (m_t % FRAME != BLANK * 2 + DWELL + 1) step(1'b0, 4'h0, 4'h0);
    check_model("pre_reset");
    #2 reset = 1'b0;
    #1;
    check("async_rst.an_en",      {6'd0, bus.an_en},      8'h03);
    check("async_rst.hex_sel",    {4'd0, bus.hex_sel},    8'h00);
    check("async_rst.pending",    {7'd0, bus.pending},    8'h00);
    check("async_rst.frame_tick", {7'd0, bus.frame_tick}, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    check_model("post_rst0");
    for (int k = 0; k < FRAME + 2; k++) begin
      step(1'b0, 4'h0, 4'h0);
      check_model($sformatf("post_rst%0d", k + 1));
    end

    // Leading-zero digit A, then a nonzero A, each loaded on a commit edge.
    while ((m_t + 1) % FRAME != 0) step(1'b0, 4'h0, 4'h0);
    step(1'b1, 4'h0, 4'h5);
    check_model("lz05_0");
    for (int k = 1; k < FRAME; k++) begin
      step(1'b0, 4'h0, 4'h0);
      check_model($sformatf("lz05_%0d", k));
    end
    step(1'b1, 4'h2, 4'h5);
    check_model("lz25_0");
    for (int k = 1; k < FRAME; k++) begin
      step(1'b0, 4'h0, 4'h0);
      check_model($sformatf("lz25_%0d", k));
    end

    // Random loads at random phases against the model.
    for (int k = 0; k < 1500; k++) begin
      logic ld;
      ld = ($urandom_range(0, 5) == 0);
      step(ld, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      check_model($sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
